// File: rtl/fetch_pkg.sv
// Shared constants, FSM encoding and buffer payload for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] NOOP_INSTR     = 32'hFC00_0000;
   localparam logic [XLEN-1:0] DEF_RESET_PC   = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEF_EXC_VECTOR = 32'h0000_0180;
   localparam logic [XLEN-1:0] PC_STEP        = XLEN'(4);

   typedef enum logic [1:0] {
      S_RESET = 2'd0,
      S_REQ   = 2'd1,
      S_DROP  = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_buf_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/if_next_pc.sv
// Next-PC selection: redirect priority (branch over jump), target alignment handling, PC+4.
module if_next_pc
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] EXC_VECTOR  = DEF_EXC_VECTOR,
   parameter bit              ALIGN_CHECK = 1'b0
) (
   input  logic            branch_i,
   input  logic [XLEN-1:0] branch_pc_i,
   input  logic            jump_i,
   input  logic [XLEN-1:0] jump_pc_i,
   input  logic [XLEN-1:0] seq_pc_i,
   output logic [XLEN-1:0] next_pc_o,
   output logic            redirect_o,
   output logic            misalign_o
);

   logic [XLEN-1:0] target;

   assign redirect_o = branch_i | jump_i;

   always_comb begin
      target     = branch_i ? branch_pc_i : jump_pc_i;
      misalign_o = 1'b0;
      next_pc_o  = seq_pc_i + PC_STEP;
      if (branch_i | jump_i) begin
         if (!ALIGN_CHECK) begin
            next_pc_o = word_align(target);
         end else if (target[1:0] != 2'b00) begin
            misalign_o = 1'b1;
            next_pc_o  = EXC_VECTOR;
         end else begin
            next_pc_o = target;
         end
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, keeps one imem request in flight, holds one instruction.
// Define ALIGN_CHECK_EN to trap misaligned redirect targets to EXC_VECTOR (else bits [1:0] are masked).
module if_fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = DEF_RESET_PC,
   parameter logic [XLEN-1:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            Stall_ID,
   input  logic            Jump_ID,
   input  logic [XLEN-1:0] Jump_PC_ID,
   input  logic            Branch_EX,
   input  logic [XLEN-1:0] Branch_PC_EX,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   output logic [XLEN-1:0] PC_IF,
   output logic [XLEN-1:0] Instruction_IF,
   output logic            Flush_IF,
   output logic            Fetch_Misalign
);

`ifdef ALIGN_CHECK_EN
   localparam bit ALIGN_CHECK = 1'b1;
`else
   localparam bit ALIGN_CHECK = 1'b0;
`endif

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] req_addr_q, req_addr_d;
   fetch_buf_t      buf_q, buf_d;
   logic            outstanding_q, outstanding_d;
   logic            misalign_q, misalign_d;

   logic            issue_c;
   logic            ack_c;
   logic            redirect;
   logic            misalign;
   logic [XLEN-1:0] next_pc;
   logic [XLEN-1:0] seq_pc;

   // Address of the request on the bus: the held one if in flight, else the PC about to issue.
   assign seq_pc = outstanding_q ? req_addr_q : pc_q;
   assign ack_c  = imem_ack & imem_req;

   if_next_pc #(
      .EXC_VECTOR  (EXC_VECTOR),
      .ALIGN_CHECK (ALIGN_CHECK)
   ) u_next_pc (
      .branch_i    (Branch_EX),
      .branch_pc_i (Branch_PC_EX),
      .jump_i      (Jump_ID),
      .jump_pc_i   (Jump_PC_ID),
      .seq_pc_i    (seq_pc),
      .next_pc_o   (next_pc),
      .redirect_o  (redirect),
      .misalign_o  (misalign)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RESET;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET: state_d = S_REQ;
         S_REQ:   if (redirect && outstanding_q && !ack_c) state_d = S_DROP;
         S_DROP:  if (ack_c) state_d = S_REQ;
         default: state_d = S_RESET;
      endcase
   end

   // Request handshake: once raised, req/addr hold until ack regardless of stall or redirect.
   always_comb begin
      issue_c   = 1'b0;
      imem_req  = 1'b0;
      imem_addr = '0;
      case (state_q)
         S_REQ: begin
            issue_c  = !outstanding_q && (!buf_q.valid || !Stall_ID) && !redirect;
            imem_req = outstanding_q | issue_c;
         end
         S_DROP:  imem_req = outstanding_q;
         default: imem_req = 1'b0;
      endcase
      if (imem_req) imem_addr = word_align(seq_pc);
   end

   always_comb begin
      pc_d          = pc_q;
      req_addr_d    = req_addr_q;
      buf_d         = buf_q;
      outstanding_d = outstanding_q;
      misalign_d    = redirect & misalign;
      if (issue_c) begin
         req_addr_d    = pc_q;
         outstanding_d = 1'b1;
      end
      if (ack_c) outstanding_d = 1'b0;
      // Redirect discards the buffer and any data returning for the wrong path.
      if (redirect) begin
         pc_d        = next_pc;
         buf_d.valid = 1'b0;
      end else if (ack_c && state_q == S_REQ) begin
         pc_d        = next_pc;
         buf_d.valid = 1'b1;
         buf_d.pc    = seq_pc;
         buf_d.instr = imem_rdata;
      end else if (buf_q.valid && !Stall_ID) begin
         buf_d.valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         req_addr_q    <= '0;
         buf_q         <= '{valid: 1'b0, pc: '0, instr: NOOP_INSTR};
         outstanding_q <= 1'b0;
         misalign_q    <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         req_addr_q    <= req_addr_d;
         buf_q         <= buf_d;
         outstanding_q <= outstanding_d;
         misalign_q    <= misalign_d;
      end
   end

   assign PC_IF          = buf_q.pc;
   assign Instruction_IF = buf_q.valid ? buf_q.instr : NOOP_INSTR;
   assign Flush_IF       = ~buf_q.valid | Jump_ID | Branch_EX;
   assign Fetch_Misalign = misalign_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed fetch/stall/redirect scenarios over a latency-configurable imem.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        Stall_ID;
   logic        Jump_ID;
   logic [31:0] Jump_PC_ID;
   logic        Branch_EX;
   logic [31:0] Branch_PC_EX;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] PC_IF;
   logic [31:0] Instruction_IF;
   logic        Flush_IF;
   logic        Fetch_Misalign;

   int          checks  = 0;
   int          errors  = 0;
   int          mem_lat = 1;
   logic [31:0] exp_q[$];

`ifdef ALIGN_CHECK_EN
   localparam logic [31:0] MIS_TGT = 32'h0000_0180;
   localparam logic [31:0] MIS_EXP = 32'd1;
`else
   localparam logic [31:0] MIS_TGT = 32'h0000_0100;
   localparam logic [31:0] MIS_EXP = 32'd0;
`endif
   localparam logic [31:0] NOOP = 32'hFC00_0000;

   if_fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .Stall_ID       (Stall_ID),
      .Jump_ID        (Jump_ID),
      .Jump_PC_ID     (Jump_PC_ID),
      .Branch_EX      (Branch_EX),
      .Branch_PC_EX   (Branch_PC_EX),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .PC_IF          (PC_IF),
      .Instruction_IF (Instruction_IF),
      .Flush_IF       (Flush_IF),
      .Fetch_Misalign (Fetch_Misalign)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return 32'h2000_0000 ^ a;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory: acks in the mem_lat-th cycle of a request (1 = same cycle); checks req/addr hold.
   initial begin : memory_model
      int          wait_cnt;
      logic        pend;
      logic [31:0] pend_addr;
      wait_cnt   = 0;
      pend       = 1'b0;
      pend_addr  = '0;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      forever begin
         @(negedge clk);
         #1;
         if (pend) begin
            check("req_held", 32'(imem_req), 32'd1);
            check("addr_held", imem_addr, pend_addr);
         end
         if (imem_req) begin
            if (wait_cnt >= mem_lat - 1) begin
               imem_ack   = 1'b1;
               imem_rdata = instr_of(imem_addr);
               wait_cnt   = 0;
               pend       = 1'b0;
            end else begin
               imem_ack  = 1'b0;
               wait_cnt++;
               pend      = 1'b1;
               pend_addr = imem_addr;
            end
         end else begin
            imem_ack = 1'b0;
            wait_cnt = 0;
            pend     = 1'b0;
         end
      end
   end

   // Monitor: an instruction moves into ID whenever it is presented unflushed and ID is not stalled.
   initial begin : monitor
      logic [31:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && !Flush_IF && !Stall_ID) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL xfer_extra: got pc %h expected no transfer", PC_IF);
            end else begin
               e = exp_q.pop_front();
               check("xfer_pc", PC_IF, e);
               check("xfer_instr", Instruction_IF, instr_of(e));
            end
         end
      end
   end

   task automatic tick(input logic st, input logic jp, input logic [31:0] jpc,
                       input logic br, input logic [31:0] bpc);
      @(negedge clk);
      Stall_ID     = st;
      Jump_ID      = jp;
      Jump_PC_ID   = jpc;
      Branch_EX    = br;
      Branch_PC_EX = bpc;
      #2;
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      rst          = 1'b1;
      Stall_ID     = 1'b0;
      Jump_ID      = 1'b0;
      Jump_PC_ID   = '0;
      Branch_EX    = 1'b0;
      Branch_PC_EX = '0;

      idle(1);
      check("rst_pc_if", PC_IF, 32'h0);
      check("rst_instr", Instruction_IF, NOOP);
      check("rst_flush", 32'(Flush_IF), 32'd1);
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_misalign", 32'(Fetch_Misalign), 32'd0);
      idle(1);
      rst = 1'b0;
      check("sreset_req", 32'(imem_req), 32'd0);

      // Zero-wait memory: back-to-back fetch from RESET_PC.
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      exp_q.push_back(32'hC);
      idle(1);
      check("first_req", 32'(imem_req), 32'd1);
      check("first_addr", imem_addr, 32'h0);
      idle(3);

      // Three-cycle memory: request for 0x10 held while NOOP is presented.
      mem_lat = 3;
      exp_q.push_back(32'h10);
      idle(1);
      check("lat_req", 32'(imem_req), 32'd1);
      check("lat_addr", imem_addr, 32'h10);
      for (int i = 0; i < 2; i++) begin
         idle(1);
         check("lat_flush", 32'(Flush_IF), 32'd1);
         check("lat_instr", Instruction_IF, NOOP);
         check("lat_addr_wait", imem_addr, 32'h10);
      end
      exp_q.push_back(32'h14);
      idle(2);

      // Stall: in-flight 0x14 lands in the buffer and is held, no new request.
      tick(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
         check("stall_req", 32'(imem_req), 32'd0);
         check("stall_pc", PC_IF, 32'h14);
         check("stall_instr", Instruction_IF, instr_of(32'h14));
      end
      exp_q.push_back(32'h18);
      idle(3);
      mem_lat = 4;
      exp_q.push_back(32'h1C);
      idle(5);

      // Taken branch while 0x20 is in flight: its data must be dropped.
      exp_q.push_back(32'h100);
      tick(1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
      check("br_flush", 32'(Flush_IF), 32'd1);
      check("br_addr_hold", imem_addr, 32'h20);
      idle(1);
      check("drop_req", 32'(imem_req), 32'd1);
      check("drop_addr", imem_addr, 32'h20);
      idle(2);
      check("br_new_req", 32'(imem_req), 32'd1);
      check("br_new_addr", imem_addr, 32'h100);
      idle(3);
      mem_lat = 1;
      idle(1);

      // Same-cycle jump and branch: branch target wins, buffered 0x104 is flushed.
      exp_q.push_back(32'h80);
      exp_q.push_back(32'h84);
      tick(1'b0, 1'b1, 32'h40, 1'b1, 32'h80);
      check("jb_flush", 32'(Flush_IF), 32'd1);
      check("jb_req", 32'(imem_req), 32'd0);
      idle(1);
      check("jb_addr", imem_addr, 32'h80);
      check("jb_misalign", 32'(Fetch_Misalign), 32'd0);
      idle(2);

      // Misaligned branch target.
      exp_q.push_back(MIS_TGT);
      exp_q.push_back(MIS_TGT + 32'h4);
      tick(1'b0, 1'b0, 32'h0, 1'b1, 32'h102);
      check("mis_flush", 32'(Flush_IF), 32'd1);
      idle(1);
      check("mis_pulse", 32'(Fetch_Misalign), MIS_EXP);
      check("mis_addr", imem_addr, MIS_TGT);
      idle(1);
      check("mis_pulse_end", 32'(Fetch_Misalign), 32'd0);
      idle(1);

      // PC wrap at the top of the address space.
      exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'h0);
      tick(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
      idle(2);
      check("wrap_req", 32'(imem_req), 32'd1);
      check("wrap_addr", imem_addr, 32'h0);
      idle(1);
      tick(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      tick(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction Fetch stage. Owns the PC, issues requests to instruction memory, and holds one fetched instruction in a skid buffer.
- Drives PC_IF, Instruction_IF and Flush_IF directly into the IF/ID pipeline register. Accepts redirects from ID (jump) and EX (taken branch).
- Honours Stall_ID backpressure and variable-latency instruction memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- EXC_VECTOR, 32'h0000_0180, fetch target on misaligned redirect (ALIGN_CHECK_EN only).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- Stall_ID  in  1  1: IF/ID holds its contents this cycle, so the buffer is not consumed.
- Jump_ID  in  1  jump resolved in ID this cycle.
- Jump_PC_ID  in  32  jump target.
- Branch_EX  in  1  taken branch resolved in EX this cycle.
- Branch_PC_EX  in  32  branch target.
- imem_ack  in  1  memory returns data for the outstanding request.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- imem_req  out  1  request valid.
- imem_addr  out  32  word-aligned request address.
- PC_IF  out  32  PC of the presented instruction.
- Instruction_IF  out  32  presented instruction, or NOOP 32'hFC00_0000.
- Flush_IF  out  1  1: IF/ID must load NOOP.
- Fetch_Misalign  out  1  one-cycle pulse on a misaligned redirect.

Behaviour:
- Reset:
  - Registers: PC=RESET_PC, req_addr=0, buf_valid=0, buf_pc=0, buf_instr=NOOP, state=S_RESET, outstanding=0.
  - Outputs: PC_IF=0, Instruction_IF=NOOP, Flush_IF=1, imem_req=0, imem_addr=0, Fetch_Misalign=0.
  - rst mid-request abandons the outstanding request. A late imem_ack is ignored until a new request is issued.
- State S_RESET: lasts one cycle, then goes to S_REQ.
- State S_REQ, request issue:
  - A new request issues when outstanding=0 and (buf_valid=0 or Stall_ID=0) and no redirect this cycle.
  - On issue: imem_req=1, imem_addr=PC, req_addr<=PC, outstanding<=1.
- Handshake rule: once imem_req is asserted, it and imem_addr stay stable until imem_ack, even under stall or redirect. imem_ack in the issuing cycle is legal (zero-wait memory). At most one request is outstanding.
- Ack without redirect:
  - buf_instr<=imem_rdata, buf_pc<=req_addr, buf_valid<=1, PC<=req_addr+4.
  - The ack is guaranteed to find buffer space.
- Consume: at a posedge with buf_valid=1 and Stall_ID=0, the buffer is consumed. If a same-cycle ack also arrives, the buffer is refilled; otherwise buf_valid<=0.
- Throughput: 1 instruction/cycle with zero-wait memory. Latency is 1 cycle from ack to presentation.
- Presentation (combinational from the buffer):
  - Instruction_IF = buf_valid ? buf_instr : NOOP.
  - PC_IF = buf_pc.
  - Flush_IF = ~buf_valid | Jump_ID | Branch_EX.
- Redirect priority: Branch_EX over Jump_ID (the older instruction wins).
- Redirect effect:
  - PC<=target, buf_valid<=0.
  - If a request is outstanding and not acked this cycle, go to S_DROP.
  - If it is acked this cycle, discard the data and stay in S_REQ.
- State S_DROP:
  - imem_req stays high with the old req_addr. On ack, discard the data, set outstanding<=0, go to S_REQ.
  - A further redirect in S_DROP only updates PC.
- PC arithmetic: 32-bit wrap, so 32'hFFFF_FFFC+4 = 0.

Optional Feature:
- ALIGN_CHECK_EN defined: a redirect target with [1:0]!=0 sets PC<=EXC_VECTOR and pulses Fetch_Misalign for one cycle.
- ALIGN_CHECK_EN undefined: target bits [1:0] are forced to 0 and Fetch_Misalign is tied to 0.
- The port exists in both builds.

Decomposition:
- Package fetch_pkg: NOOP_INSTR=32'hFC00_0000, state encoding S_RESET/S_REQ/S_DROP, default RESET_PC/EXC_VECTOR.
- Sub-module if_next_pc (combinational): redirect priority mux, alignment check/masking, PC+4. Outputs next_pc, redirect, misalign.

Test Plan:
- Reset with zero-wait memory (ack in the same cycle as req): first fetch is 0x0; from the 2nd post-reset cycle, PC_IF steps 0x0, 0x4, 0x8 each cycle and Flush_IF=0.
- Memory with 3-cycle ack latency: imem_req is held 3 cycles with imem_addr=0x4. Flush_IF=1 and Instruction_IF=0xFC000000 during the wait; then PC_IF=0x4.
- Stall_ID=1 for 4 cycles with buf_valid=1: PC_IF and Instruction_IF are stable, no new request issues, and the in-flight ack is absorbed. Release gives no loss or duplication.
- Branch_EX=1 with Branch_PC_EX=0x100 while a request for 0x20 is outstanding (ack 2 cycles later): Flush_IF=1 that cycle, the 0x20 data is dropped, the next request goes to 0x100, and PC_IF=0x100.
- Same-cycle Jump_ID (0x40) and Branch_EX (0x80): the next fetch is 0x80.
- With ALIGN_CHECK_EN, Branch_PC_EX=0x102: Fetch_Misalign=1 for one cycle, the next fetch is 0x180. Without it, the next fetch is 0x100.
